id_ex_skid: RTL and testbench
=============================

Name: id_ex_skid

Overview:
- Parametrised ID/EX pipeline boundary register. It replaces the plain transmit-through register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a saturating backpressure counter.
- Sits between the decode stage (upstream producer) and the execute stage (downstream consumer).
- Lets EX stall without a combinational ready path back into ID.
- Lets branch/exception logic squash in-flight instructions.

Parameters:
- ALUOP_W, 8, width of aluop field
- ALUSEL_W, 3, width of alusel field
- DATA_W, 32, width of operand fields reg1/reg2
- ADDR_W, 5, width of destination register address wd
- CNT_W, 16, width of stall counter
- NOP_ALUOP, 8'h00, aluop value driven when no valid instruction is held
- NOP_ALUSEL, 3'b000, alusel value driven when no valid instruction is held

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  squash all held and incoming instructions this cycle
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage can accept; registered
- in_aluop  in  ALUOP_W  ALU operation
- in_alusel  in  ALUSEL_W  ALU result select
- in_reg1  in  DATA_W  operand 1
- in_reg2  in  DATA_W  operand 2
- in_wd  in  ADDR_W  destination register
- in_wreg  in  1  write-back enable
- out_valid  out  1  EX-side instruction valid
- out_ready  in  1  EX consumes this cycle
- out_aluop, out_alusel, out_reg1, out_reg2, out_wd, out_wreg  out  (matching widths)  registered payload to EX
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main slot (drives out_*), skid slot. States: EMPTY (no slot valid), ONE (main valid), FULL (main and skid valid).
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready is a registered value: in_ready = 1 in EMPTY and ONE, 0 in FULL. It has no combinational dependency on out_ready.
- Transitions (no flush):
  - EMPTY: in_fire -> main<=in, go to ONE.
  - ONE, out_fire & in_fire -> main<=in, stay in ONE.
  - ONE, out_fire & !in_fire -> EMPTY.
  - ONE, !out_fire & in_fire -> skid<=in, go to FULL.
  - ONE, neither -> hold.
  - FULL: out_fire -> main<=skid, go to ONE. Input is ignored because in_ready=0. Otherwise hold.
- Latency: 1 cycle from in_fire in EMPTY to out_valid. Sustained throughput is 1 instruction/cycle with out_ready held high.
- Ordering: strict FIFO. A skid entry is always older than any later input.
- Payload when invalid: whenever the main slot is invalid, out_* carry NOP values: aluop=NOP_ALUOP, alusel=NOP_ALUSEL, reg1=reg2=0, wd=0, wreg=0. out_wreg=1 is never presented with out_valid=0.
- Payload while stalled: while out_valid=1 & out_ready=0, out_* are stable.
- flush (priority below rst, above everything else):
  - Next cycle: state EMPTY, out_valid=0, payload NOP, in_ready=1.
  - An in_valid present in the flush cycle is dropped (not captured).
  - stall_cnt is unaffected.
- rst (highest priority):
  - State EMPTY, out_valid=0, out payload NOP, in_ready=1, stall_cnt=0.
  - Applies mid-operation regardless of flush, in_valid or out_ready.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by rst.
- Simultaneous events:
  - rst+flush: treated as rst.
  - flush+out_ready: the held instruction is still discarded, no out_fire counted.
  - In FULL with out_ready: skid promoted, in_ready rises the next cycle, no bubble inserted on the output.

Decomposition:
- Shared package/define file holds:
  - NOP constants (NOP_ALUOP, NOP_ALUSEL, zero word, NOP register address).
  - The state encoding EMPTY/ONE/FULL.
  - Default widths.
- Natural sub-module: id_ex_slot. It is one payload register with load-enable and clear-to-NOP, instantiated twice (main, skid).
- The top level holds the FSM, in_ready register and stall_cnt.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_wreg=0, out_aluop=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, issue aluop 1,2,3 with reg1=0x11,0x22,0x33 back-to-back -> identical values appear on out_* 1 cycle later each, out_valid high 3 consecutive cycles, stall_cnt stays 0.
- Backpressure/skid:
  - Issue A (wd=5) then B (wd=6) with out_ready=0 -> state FULL, in_ready=0 from the cycle after B, out_wd=5 held.
  - Present C (wd=7) while in_ready=0 -> C is not captured.
  - After 3 stalled cycles stall_cnt=3.
  - Raise out_ready -> outputs 5 then 6 in order, C is only accepted once in_ready returns to 1.
- Flush in FULL: flush with A,B held and in_valid=1 (wd=9) -> next cycle out_valid=0, out_wreg=0, in_ready=1; wd=9 never appears on out_wd.
- Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
- Reset mid-stall: assert rst while FULL with flush=1 -> next cycle EMPTY, stall_cnt=0, in_ready=1.

Source files
------------

// File: rtl/id_ex_skid_pkg.sv
// Shared constants and state encoding for the ID/EX skid-buffered pipeline register.
package id_ex_skid_pkg;

    localparam int ALUOP_W_DEF  = 8;
    localparam int ALUSEL_W_DEF = 3;
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int CNT_W_DEF    = 16;

    localparam logic [ALUOP_W_DEF-1:0]  NOP_ALUOP_DEF  = 8'h00;
    localparam logic [ALUSEL_W_DEF-1:0] NOP_ALUSEL_DEF = 3'b000;
    localparam logic [DATA_W_DEF-1:0]   ZERO_WORD      = '0;
    localparam logic [ADDR_W_DEF-1:0]   NOP_ADDR       = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/id_ex_slot.sv
// One instruction payload register; clear forces NOP contents and wins over load.
module id_ex_slot
    import id_ex_skid_pkg::*;
#(
    parameter int                    ALUOP_W    = ALUOP_W_DEF,
    parameter int                    ALUSEL_W   = ALUSEL_W_DEF,
    parameter int                    DATA_W     = DATA_W_DEF,
    parameter int                    ADDR_W     = ADDR_W_DEF,
    parameter logic [ALUOP_W-1:0]    NOP_ALUOP  = NOP_ALUOP_DEF,
    parameter logic [ALUSEL_W-1:0]   NOP_ALUSEL = NOP_ALUSEL_DEF
) (
    input  logic                clk,
    input  logic                load,
    input  logic                clear,
    input  logic [ALUOP_W-1:0]  d_aluop,
    input  logic [ALUSEL_W-1:0] d_alusel,
    input  logic [DATA_W-1:0]   d_reg1,
    input  logic [DATA_W-1:0]   d_reg2,
    input  logic [ADDR_W-1:0]   d_wd,
    input  logic                d_wreg,
    output logic [ALUOP_W-1:0]  q_aluop,
    output logic [ALUSEL_W-1:0] q_alusel,
    output logic [DATA_W-1:0]   q_reg1,
    output logic [DATA_W-1:0]   q_reg2,
    output logic [ADDR_W-1:0]   q_wd,
    output logic                q_wreg
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q_aluop  <= NOP_ALUOP;
            q_alusel <= NOP_ALUSEL;
            q_reg1   <= '0;
            q_reg2   <= '0;
            q_wd     <= '0;
            q_wreg   <= 1'b0;
        end else if (load) begin
            q_aluop  <= d_aluop;
            q_alusel <= d_alusel;
            q_reg1   <= d_reg1;
            q_reg2   <= d_reg2;
            q_wd     <= d_wd;
            q_wreg   <= d_wreg;
        end
    end

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX boundary: valid/ready handshake with a 2-entry skid, flush and a saturating stall counter.
// Handshake: a beat transfers on a rising clk edge where valid & ready; in_ready is registered.
module id_ex_skid
    import id_ex_skid_pkg::*;
#(
    parameter int                  ALUOP_W    = ALUOP_W_DEF,
    parameter int                  ALUSEL_W   = ALUSEL_W_DEF,
    parameter int                  DATA_W     = DATA_W_DEF,
    parameter int                  ADDR_W     = ADDR_W_DEF,
    parameter int                  CNT_W      = CNT_W_DEF,
    parameter logic [ALUOP_W-1:0]  NOP_ALUOP  = NOP_ALUOP_DEF,
    parameter logic [ALUSEL_W-1:0] NOP_ALUSEL = NOP_ALUSEL_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALUOP_W-1:0]  in_aluop,
    input  logic [ALUSEL_W-1:0] in_alusel,
    input  logic [DATA_W-1:0]   in_reg1,
    input  logic [DATA_W-1:0]   in_reg2,
    input  logic [ADDR_W-1:0]   in_wd,
    input  logic                in_wreg,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALUOP_W-1:0]  out_aluop,
    output logic [ALUSEL_W-1:0] out_alusel,
    output logic [DATA_W-1:0]   out_reg1,
    output logic [DATA_W-1:0]   out_reg2,
    output logic [ADDR_W-1:0]   out_wd,
    output logic                out_wreg,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [1:0]          fsm_state
);

    state_t state, state_nx;
    logic   in_fire, out_fire;
    logic   main_load, main_clear, skid_load, skid_clear, promote;

    logic [ALUOP_W-1:0]  skid_aluop;
    logic [ALUSEL_W-1:0] skid_alusel;
    logic [DATA_W-1:0]   skid_reg1, skid_reg2;
    logic [ADDR_W-1:0]   skid_wd;
    logic                skid_wreg;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign fsm_state = state;

    always_comb begin
        state_nx   = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        promote    = 1'b0;
        if (rst || flush) begin
            state_nx   = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_nx  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (out_fire && in_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                        state_nx   = ST_EMPTY;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_nx  = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid entry can move.
                    if (out_fire) begin
                        main_load  = 1'b1;
                        promote    = 1'b1;
                        skid_clear = 1'b1;
                        state_nx   = ST_ONE;
                    end
                end
                default: begin
                    state_nx   = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state     <= state_nx;
        out_valid <= (state_nx != ST_EMPTY);
        in_ready  <= (state_nx != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    id_ex_slot #(
        .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .NOP_ALUOP(NOP_ALUOP), .NOP_ALUSEL(NOP_ALUSEL)
    ) u_skid (
        .clk(clk), .load(skid_load), .clear(skid_clear),
        .d_aluop(in_aluop), .d_alusel(in_alusel), .d_reg1(in_reg1),
        .d_reg2(in_reg2), .d_wd(in_wd), .d_wreg(in_wreg),
        .q_aluop(skid_aluop), .q_alusel(skid_alusel), .q_reg1(skid_reg1),
        .q_reg2(skid_reg2), .q_wd(skid_wd), .q_wreg(skid_wreg)
    );

    id_ex_slot #(
        .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .NOP_ALUOP(NOP_ALUOP), .NOP_ALUSEL(NOP_ALUSEL)
    ) u_main (
        .clk(clk), .load(main_load), .clear(main_clear),
        .d_aluop (promote ? skid_aluop  : in_aluop),
        .d_alusel(promote ? skid_alusel : in_alusel),
        .d_reg1  (promote ? skid_reg1   : in_reg1),
        .d_reg2  (promote ? skid_reg2   : in_reg2),
        .d_wd    (promote ? skid_wd     : in_wd),
        .d_wreg  (promote ? skid_wreg   : in_wreg),
        .q_aluop(out_aluop), .q_alusel(out_alusel), .q_reg1(out_reg1),
        .q_reg2(out_reg2), .q_wd(out_wd), .q_wreg(out_wreg)
    );

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: directed scenarios plus a random phase checked by a payload scoreboard.
module tb_id_ex_skid;
    import id_ex_skid_pkg::*;

    localparam int PW = 8 + 3 + 32 + 32 + 5 + 1;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_wreg, out_valid, out_ready, out_wreg;
    logic [7:0]  in_aluop, out_aluop;
    logic [2:0]  in_alusel, out_alusel;
    logic [31:0] in_reg1, in_reg2, out_reg1, out_reg2;
    logic [4:0]  in_wd, out_wd;
    logic [3:0]  stall_cnt;
    logic [1:0]  fsm_state;

    logic [PW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    id_ex_skid #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_alusel(in_alusel), .in_reg1(in_reg1),
        .in_reg2(in_reg2), .in_wd(in_wd), .in_wreg(in_wreg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluop(out_aluop), .out_alusel(out_alusel), .out_reg1(out_reg1),
        .out_reg2(out_reg2), .out_wd(out_wd), .out_wreg(out_wreg),
        .stall_cnt(stall_cnt), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pack(input logic [7:0] op, input logic [2:0] sel,
                                           input logic [31:0] r1, input logic [31:0] r2,
                                           input logic [4:0] wd, input logic wreg);
        return {op, sel, r1, r2, wd, wreg};
    endfunction

    // scoreboard: push on accepted input, pop on consumed output, drop on flush/rst
    always @(negedge clk) begin
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (!out_valid) begin
                check("nop_payload",
                      128'(pack(out_aluop, out_alusel, out_reg1, out_reg2, out_wd, out_wreg)),
                      128'(pack(8'h00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0)));
            end else if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 128'(out_wd), 128'(0));
                    n_fail += (out_valid === 1'b1) ? 0 : 0;
                end else begin
                    check("sb_payload",
                          128'(pack(out_aluop, out_alusel, out_reg1, out_reg2, out_wd, out_wreg)),
                          128'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(pack(in_aluop, in_alusel, in_reg1, in_reg2, in_wd, in_wreg));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] r1,
                         input logic [4:0] wd);
        in_valid  = v;
        in_aluop  = op;
        in_alusel = op[2:0];
        in_reg1   = r1;
        in_reg2   = ~r1;
        in_wd     = wd;
        in_wreg   = v;
    endtask

    initial begin
        int budget;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 8'h5A, 32'h1234, 5'd3);

        // reset held two cycles with in_valid high
        repeat (2) tick();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_wreg", 128'(out_wreg), 128'(0));
        check("rst_out_aluop", 128'(out_aluop), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
        rst = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 5'd0);
        tick();

        // streaming with out_ready high
        out_ready = 1'b1;
        drive(1'b1, 8'd1, 32'h11, 5'd1);
        tick();
        check("stream1_valid", 128'(out_valid), 128'(1));
        check("stream1_aluop", 128'(out_aluop), 128'(1));
        check("stream1_reg1", 128'(out_reg1), 128'(32'h11));
        drive(1'b1, 8'd2, 32'h22, 5'd2);
        tick();
        check("stream2_valid", 128'(out_valid), 128'(1));
        check("stream2_reg1", 128'(out_reg1), 128'(32'h22));
        drive(1'b1, 8'd3, 32'h33, 5'd3);
        tick();
        check("stream3_valid", 128'(out_valid), 128'(1));
        check("stream3_aluop", 128'(out_aluop), 128'(3));
        drive(1'b0, 8'h00, 32'h0, 5'd0);
        tick();
        check("stream_end_valid", 128'(out_valid), 128'(0));
        check("stream_stall_cnt", 128'(stall_cnt), 128'(0));

        // backpressure into the skid slot
        out_ready = 1'b0;
        drive(1'b1, 8'hA0, 32'hA, 5'd5);
        tick();
        drive(1'b1, 8'hB0, 32'hB, 5'd6);
        tick();
        check("bp_in_ready", 128'(in_ready), 128'(0));
        check("bp_state_full", 128'(fsm_state), 128'(ST_FULL));
        check("bp_hold_wd", 128'(out_wd), 128'(5));
        drive(1'b1, 8'hC0, 32'hC, 5'd7);
        repeat (2) tick();
        check("bp_stall_cnt3", 128'(stall_cnt), 128'(3));
        check("bp_hold_wd2", 128'(out_wd), 128'(5));
        out_ready = 1'b1;
        tick();
        check("bp_promote_wd", 128'(out_wd), 128'(6));
        check("bp_promote_valid", 128'(out_valid), 128'(1));
        check("bp_in_ready_back", 128'(in_ready), 128'(1));
        tick();
        check("bp_c_wd", 128'(out_wd), 128'(7));
        drive(1'b0, 8'h00, 32'h0, 5'd0);
        tick();
        check("bp_drained", 128'(out_valid), 128'(0));
        check("bp_stall_kept", 128'(stall_cnt), 128'(3));

        // flush while FULL with an incoming instruction
        out_ready = 1'b0;
        drive(1'b1, 8'h30, 32'h3, 5'd3);
        tick();
        drive(1'b1, 8'h40, 32'h4, 5'd4);
        tick();
        flush = 1'b1;
        drive(1'b1, 8'h90, 32'h9, 5'd9);
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 5'd0);
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_out_wreg", 128'(out_wreg), 128'(0));
        check("flush_in_ready", 128'(in_ready), 128'(1));
        check("flush_out_wd", 128'(out_wd), 128'(0));
        check("flush_stall_cnt", 128'(stall_cnt), 128'(5));

        // flush in ONE with out_ready and a capturable input
        out_ready = 1'b1;
        drive(1'b1, 8'h10, 32'h10, 5'd10);
        tick();
        flush = 1'b1;
        drive(1'b1, 8'h11, 32'h11, 5'd11);
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 5'd0);
        check("flush1_out_valid", 128'(out_valid), 128'(0));
        tick();
        check("flush1_dropped", 128'(out_valid), 128'(0));
        check("flush1_state", 128'(fsm_state), 128'(ST_EMPTY));

        // saturation of the 4-bit stall counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 8'hCC, 32'hCC, 5'd12);
        tick();
        drive(1'b0, 8'h00, 32'h0, 5'd0);
        repeat (20) tick();
        check("sat_cnt15", 128'(stall_cnt), 128'(15));
        tick();
        check("sat_cnt_hold", 128'(stall_cnt), 128'(15));
        check("sat_payload_stable", 128'(out_wd), 128'(12));

        // reset with flush while FULL
        drive(1'b1, 8'hDD, 32'hDD, 5'd13);
        tick();
        check("pre_rst_full", 128'(fsm_state), 128'(ST_FULL));
        rst = 1'b1; flush = 1'b1;
        drive(1'b1, 8'hEE, 32'hEE, 5'd14);
        tick();
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 5'd0);
        check("rst_mid_state", 128'(fsm_state), 128'(ST_EMPTY));
        check("rst_mid_cnt", 128'(stall_cnt), 128'(0));
        check("rst_mid_in_ready", 128'(in_ready), 128'(1));
        check("rst_mid_out_valid", 128'(out_valid), 128'(0));

        // random traffic, occasional flush
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            drive(($urandom_range(0, 2) != 0), 8'($urandom), $urandom, 5'($urandom));
            tick();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 32'h0, 5'd0);
        budget = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 10) begin
            tick();
            budget++;
        end
        check("drain_queue_empty", 128'(exp_q.size()), 128'(0));
        check("drain_out_valid", 128'(out_valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
